// File: rtl/reg_bank_wb.sv
// Register bank with a three-state write-back handshake plus HI/LO registers.
// Optional macro WB_BYPASS_EN forwards the committing write to same-cycle reads.
module reg_bank_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteDataIn,
    output logic        wr_ack,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    input  logic        HILOWrite,
    input  logic [31:0] HIin,
    input  logic [31:0] LOin,
    output logic [31:0] HIout,
    output logic [31:0] LOout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        COMMIT
    } state_t;

    state_t      state;
    logic [4:0]  pend_idx;
    logic [31:0] pend_data;
    logic [31:0] regs [32];

    // busy and wr_ack are registered so they line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            wr_ack    <= 1'b0;
            pend_idx  <= 5'd0;
            pend_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ack <= 1'b0;
                    busy   <= 1'b0;
                    if (wr_req) begin
                        pend_idx  <= WriteReg;
                        pend_data <= WriteDataIn;
                        busy      <= 1'b1;
                        state     <= LATCH;
                    end
                end
                LATCH: begin
                    busy   <= 1'b1;
                    wr_ack <= 1'b1;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    busy   <= 1'b0;
                    wr_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    wr_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Register 29 is the stack pointer and comes out of reset pointing at 227
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? 32'd227 : 32'd0;
            end
        end else if (state == COMMIT && pend_idx != 5'd0) begin
            regs[pend_idx] <= pend_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HIout <= 32'd0;
            LOout <= 32'd0;
        end else if (HILOWrite) begin
            HIout <= HIin;
            LOout <= LOin;
        end
    end

    // regs[0] is never written, so index 0 always reads zero
    always_comb begin
        ReadData1 = regs[ReadReg1];
        ReadData2 = regs[ReadReg2];
`ifdef WB_BYPASS_EN
        if (state == COMMIT && pend_idx != 5'd0) begin
            if (ReadReg1 == pend_idx) ReadData1 = pend_data;
            if (ReadReg2 == pend_idx) ReadData2 = pend_data;
        end
`endif
    end

endmodule

// File: doc/reg_bank_wb.md
REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have reset `reset`, input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have `wr_req`, input, 1 bit, write-back request from the write-data selector stage.
REQ-004 SHALL have `WriteReg`, input, 5 bits, destination register index.
REQ-005 SHALL have `WriteDataIn`, input, 32 bits, selected write-back value.
REQ-006 SHALL have `wr_ack`, output, 1 bit, one-cycle pulse when a write commits.
REQ-007 SHALL have `ReadReg1` and `ReadReg2`, inputs, 5 bits each, read indices.
REQ-008 SHALL have `ReadData1` and `ReadData2`, outputs, 32 bits each, read data.
REQ-009 SHALL have `HILOWrite`, input, 1 bit, and `HIin`/`LOin`, inputs, 32 bits each, which load HI/LO.
REQ-010 SHALL have `HIout` and `LOout`, outputs, 32 bits each, the current HI/LO contents.
REQ-011 SHALL have `busy`, output, 1 bit, high while a write is held pending.

Function
REQ-012 SHALL hold 32 general registers of 32 bits, plus separate HI and LO registers.
REQ-013 Reads SHALL be combinational: ReadDataN = reg[ReadRegN].
REQ-014 Index 0 SHALL always read 0; writes to index 0 SHALL be accepted and acked but SHALL NOT change state.
REQ-015 FSM states SHALL be IDLE, LATCH and COMMIT.
REQ-016 IDLE: if wr_req=1, SHALL capture WriteReg/WriteDataIn into a pending buffer and go to LATCH; busy=0 in IDLE.
REQ-017 LATCH: SHALL set busy=1 and go to COMMIT; wr_req SHALL be ignored.
REQ-018 COMMIT: SHALL write the buffered data to the buffered index, assert wr_ack for exactly this cycle, keep busy=1, and return to IDLE.
REQ-019 Request-to-ack latency SHALL be 2 cycles after the capture edge; the register becomes visible on reads the cycle after COMMIT.
REQ-020 wr_req asserted while busy=1 SHALL be dropped; the source SHALL hold wr_req until it sees wr_ack.
REQ-021 HILOWrite=1 SHALL load HI=HIin and LO=LOin on the next edge, independent of the FSM; HI/LO writes SHALL have no ordering dependence on general-register writes.
REQ-022 Input changes on WriteReg/WriteDataIn after capture SHALL NOT affect the committed value.

Reset
REQ-023 reset=1 SHALL immediately force the FSM to IDLE, busy=0 and wr_ack=0, and SHALL clear the pending buffer.
REQ-024 Reset SHALL clear all registers and HI/LO to 0, except reg[29] (stack pointer), which SHALL reset to 32'd227.
REQ-025 Reset during LATCH or COMMIT SHALL abort the pending write with no register change and no ack.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, if the FSM is in COMMIT and ReadRegN equals the buffered nonzero index, ReadDataN SHALL return the buffered data in that cycle (write-to-read forwarding).
REQ-027 Without WB_BYPASS_EN, reads SHALL return only the stored register contents; the new value is visible from the cycle after COMMIT.

Verification
REQ-028 Reset: assert reset mid-cycle -> all ReadData are 0 except ReadReg=29, which reads 227; busy=0; HIout=LOout=0.
REQ-029 Write: wr_req with WriteReg=5 and WriteDataIn=0xDEADBEEF -> wr_ack pulses 2 cycles later; the next cycle ReadData1 with ReadReg1=5 reads 0xDEADBEEF.
REQ-030 Zero register: write 0x1234 to index 0 -> wr_ack pulses; ReadReg=0 still reads 0.
REQ-031 Busy drop: a second wr_req (reg 6, 0x55) pulsed only in LATCH -> no write to reg 6; a held request commits after the first ack.
REQ-032 Abort: reset during COMMIT of reg 7 = 0xAA -> no ack; reg 7 reads 0.
REQ-033 Bypass/HI-LO: with WB_BYPASS_EN, ReadReg2=5 during COMMIT of 0x77 -> reads 0x77 in that cycle (without the macro, reads the old value); HILOWrite with HIin=1, LOin=2 -> HIout=1 and LOout=2 on the next cycle.
